// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: controller state encoding and datapath mux selects.
package gcd_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // One-hot states so in_ready/out_valid come straight off a state flop.
  localparam int unsigned IDLE_BIT = 0;
  localparam int unsigned CALC_BIT = 1;
  localparam int unsigned DONE_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_CALC = 3'b010,
    ST_DONE = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    A_SEL_LOAD = 2'd0,
    A_SEL_SUB  = 2'd1,
    A_SEL_SWAP = 2'd2
  } a_sel_e;

  typedef enum logic {
    B_SEL_LOAD = 1'b0,
    B_SEL_SWAP = 1'b1
  } b_sel_e;

endpackage

// File: rtl/gcd_datapath.sv
// GCD datapath: operand registers with load/subtract/swap muxes and the two
// comparators the controller steers on.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             a_en_i,
  input  logic             b_en_i,
  input  a_sel_e           a_sel_i,
  input  b_sel_e           b_sel_i,
  output logic [WIDTH-1:0] reg_a_o,
  output logic             b_eq_0_c_o,
  output logic             a_lt_b_c_o
);

  logic [WIDTH-1:0] reg_a_q, reg_a_d;
  logic [WIDTH-1:0] reg_b_q, reg_b_d;

  // Next-value muxes; subtract wraps at WIDTH bits with no carry out.
  always_comb begin
    reg_a_d = reg_a_q;
    case (a_sel_i)
      A_SEL_LOAD: reg_a_d = in_a_i;
      A_SEL_SUB:  reg_a_d = reg_a_q - reg_b_q;
      A_SEL_SWAP: reg_a_d = reg_b_q;
      default:    reg_a_d = reg_a_q;
    endcase
    reg_b_d = (b_sel_i == B_SEL_SWAP) ? reg_a_q : in_b_i;
  end

  // Operand registers, each updated only when its enable is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else begin
      if (a_en_i) reg_a_q <= reg_a_d;
      if (b_en_i) reg_b_q <= reg_b_d;
    end
  end

  assign reg_a_o    = reg_a_q;
  assign b_eq_0_c_o = (reg_b_q == '0);
  assign a_lt_b_c_o = (reg_a_q < reg_b_q);

endmodule

// File: rtl/gcd_engine.sv
// Subtract-and-swap GCD engine: valid/ready operand intake, Euclid iteration,
// result held until the sink takes it.
// Optional feature: define GCD_ITER_CNT_EN to add the iter_cnt step counter port.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [CNT_W-1:0] iter_cnt
`endif
);

  state_e state_q, state_d;
  logic   a_en, b_en;
  a_sel_e a_sel;
  b_sel_e b_sel;
  logic   b_eq_0, a_lt_b;

  gcd_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .a_en_i     (a_en),
    .b_en_i     (b_en),
    .a_sel_i    (a_sel),
    .b_sel_i    (b_sel),
    .reg_a_o    (result),
    .b_eq_0_c_o (b_eq_0),
    .a_lt_b_c_o (a_lt_b)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath controls; one CALC action per cycle, zero-check first.
  always_comb begin
    state_d = state_q;
    a_en    = 1'b0;
    b_en    = 1'b0;
    a_sel   = A_SEL_LOAD;
    b_sel   = B_SEL_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_en    = 1'b1;
          b_en    = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (b_eq_0) begin
          state_d = ST_DONE;
        end else if (a_lt_b) begin
          a_en  = 1'b1;
          b_en  = 1'b1;
          a_sel = A_SEL_SWAP;
          b_sel = B_SEL_SWAP;
        end else begin
          a_en  = 1'b1;
          a_sel = A_SEL_SUB;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are single state flops, so no input reaches them combinationally.
  assign in_ready  = state_q[IDLE_BIT];
  assign out_valid = state_q[DONE_BIT];

`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_c, step_c;

  assign load_c = state_q[IDLE_BIT] & in_valid;
  assign step_c = state_q[CALC_BIT] & ~b_eq_0;

  // Step counter: clears on accept, saturates at all-ones, holds otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (load_c) cnt_d = '0;
    else if (step_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Step counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign iter_cnt = cnt_q;
`endif

endmodule
